// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS main control unit: FSM states,
// instruction opcode/funct fields, ALU operation classes and ALU controls.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTE  = 4'd6,
        ALUWB    = 4'd7,
        BRANCH   = 4'd8,
        ADDIEXEC = 4'd9,
        ADDIWB   = 4'd10,
        JUMP     = 4'd11
    } state_t;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes (IR[5:0])
    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;
    localparam logic [5:0] FUNCT_SLT = 6'h2A;

    // ALU operation class handed from the FSM to the ALU decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_RSVD  = 2'b11;

    // ALU control encodings
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // True for every opcode the core executes; anything else is flagged in DECODE.
    function automatic logic is_legal_opcode(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_J) || (op == OP_BEQ) ||
               (op == OP_ADDI) || (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/mips_alu_decoder.sv
// ALU decoder: maps the FSM's ALU operation class and the R-type funct field
// onto the ALU control lines. Purely combinational.
module mips_alu_decoder
    import mips_ctrl_pkg::*;
#(
    parameter int OP_W      = 6,
    parameter int ALUCTRL_W = 3
) (
    input  logic [1:0]           alu_op,
    input  logic [OP_W-1:0]      funct,
    output logic [ALUCTRL_W-1:0] alu_control
);

    // Unknown funct and the unreachable class 11 both fall back to add, silently.
    always_comb begin
        alu_control = ALUCTRL_W'(ALU_ADD);
        case (alu_op)
            ALUOP_ADD: alu_control = ALUCTRL_W'(ALU_ADD);
            ALUOP_SUB: alu_control = ALUCTRL_W'(ALU_SUB);
            ALUOP_FUNCT: begin
                case (funct)
                    FUNCT_ADD: alu_control = ALUCTRL_W'(ALU_ADD);
                    FUNCT_SUB: alu_control = ALUCTRL_W'(ALU_SUB);
                    FUNCT_AND: alu_control = ALUCTRL_W'(ALU_AND);
                    FUNCT_OR:  alu_control = ALUCTRL_W'(ALU_OR);
                    FUNCT_SLT: alu_control = ALUCTRL_W'(ALU_SLT);
                    default:   alu_control = ALUCTRL_W'(ALU_ADD);
                endcase
            end
            default: alu_control = ALUCTRL_W'(ALU_ADD);
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Main control unit of the multicycle MIPS core. A Moore FSM steps the shared
// memory, IR, register file, ALU and PC through one micro-step per clock;
// datapath controls are decoded from the state register (plus opcode, funct
// and zero where needed) with no output registers.
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int OP_W      = 6,
    parameter int ALUCTRL_W = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [OP_W-1:0]      opcode,
    input  logic [OP_W-1:0]      funct,
    input  logic                 zero,
    output logic                 iord,
    output logic                 mem_write,
    output logic                 ir_write,
    output logic                 reg_dst,
    output logic                 mem_to_reg,
    output logic                 reg_write,
    output logic                 alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [1:0]           pc_src,
    output logic                 pc_en,
    output logic [ALUCTRL_W-1:0] alu_control,
    output logic                 illegal_instr,
    output logic [3:0]           state_dbg
);

    state_t     state;
    state_t     next_state;
    logic       pc_write;
    logic       branch;
    logic [1:0] alu_op;

    // State register; reset parks the machine in FETCH immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= FETCH;
        else        state <= next_state;
    end

    // Next-state logic; unused encodings fall back to FETCH.
    always_comb begin
        next_state = FETCH;
        case (state)
            FETCH:  next_state = DECODE;
            DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: next_state = MEMADR;
                    OP_RTYPE:     next_state = EXECUTE;
                    OP_BEQ:       next_state = BRANCH;
                    OP_ADDI:      next_state = ADDIEXEC;
                    OP_J:         next_state = JUMP;
                    default:      next_state = FETCH;
                endcase
            end
            MEMADR: begin
                if (opcode == OP_LW)      next_state = MEMREAD;
                else if (opcode == OP_SW) next_state = MEMWRITE;
                else                      next_state = FETCH;
            end
            MEMREAD:  next_state = MEMWB;
            MEMWB:    next_state = FETCH;
            MEMWRITE: next_state = FETCH;
            EXECUTE:  next_state = ALUWB;
            ALUWB:    next_state = FETCH;
            BRANCH:   next_state = FETCH;
            ADDIEXEC: next_state = ADDIWB;
            ADDIWB:   next_state = FETCH;
            JUMP:     next_state = FETCH;
            default:  next_state = FETCH;
        endcase
    end

    // Per-state datapath controls; write enables are masked while reset is low
    // so an aborted instruction can never complete a write.
    always_comb begin
        iord          = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        pc_src        = 2'b00;
        pc_write      = 1'b0;
        branch        = 1'b0;
        alu_op        = ALUOP_ADD;
        illegal_instr = 1'b0;
        case (state)
            FETCH: begin
                alu_src_b = 2'b01;
                ir_write  = 1'b1;
                pc_write  = 1'b1;
            end
            DECODE: begin
                // Branch target PC+4+(imm<<2) is precomputed into ALUOut here.
                alu_src_b     = 2'b11;
                illegal_instr = !is_legal_opcode(opcode);
            end
            MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            MEMREAD: iord = 1'b1;
            MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
            end
            MEMWRITE: begin
                iord      = 1'b1;
                mem_write = 1'b1;
            end
            EXECUTE: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_FUNCT;
            end
            ALUWB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
            end
            BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_SUB;
                pc_src    = 2'b01;
                branch    = 1'b1;
            end
            ADDIEXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            ADDIWB: reg_write = 1'b1;
            JUMP: begin
                pc_src   = 2'b10;
                pc_write = 1'b1;
            end
            default: ;
        endcase
        if (!rst_n) begin
            ir_write  = 1'b0;
            mem_write = 1'b0;
            reg_write = 1'b0;
            pc_write  = 1'b0;
            branch    = 1'b0;
        end
    end

    assign pc_en     = pc_write | (branch & zero);
    assign state_dbg = state;

    mips_alu_decoder #(
        .OP_W      (OP_W),
        .ALUCTRL_W (ALUCTRL_W)
    ) u_alu_decoder (
        .alu_op      (alu_op),
        .funct       (funct),
        .alu_control (alu_control)
    );

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Testbench for mips_multicycle_ctrl: table-driven instruction vectors,
// hand-written reset sequences and randomized instructions, all checked
// cycle by cycle against an instruction-level reference model.
module tb_mips_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
    logic       alu_src_a, pc_en, illegal_instr;
    logic [1:0] alu_src_b, pc_src;
    logic [2:0] alu_control;
    logic [3:0] state_dbg;

    int n_chk  = 0;
    int n_fail = 0;
    bit primed = 1'b0;

    always #5 clk = ~clk;

    mips_multicycle_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .opcode        (opcode),
        .funct         (funct),
        .zero          (zero),
        .iord          (iord),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .reg_dst       (reg_dst),
        .mem_to_reg    (mem_to_reg),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .pc_src        (pc_src),
        .pc_en         (pc_en),
        .alu_control   (alu_control),
        .illegal_instr (illegal_instr),
        .state_dbg     (state_dbg)
    );

    typedef struct packed {
        logic       iord;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic       pc_en;
        logic [2:0] alu_control;
        logic       illegal;
    } outs_t;

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        logic       z;
        int         exp_lat;
        bit         chk_alu;
        logic [2:0] exp_alu;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, wanted %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit legal_op(input logic [5:0] op);
        return op inside {6'h00, 6'h02, 6'h04, 6'h08, 6'h23, 6'h2B};
    endfunction

    function automatic logic [2:0] funct_alu(input logic [5:0] f);
        case (f)
            6'h20:   return 3'b010;
            6'h22:   return 3'b110;
            6'h24:   return 3'b000;
            6'h25:   return 3'b001;
            6'h2A:   return 3'b111;
            default: return 3'b010;
        endcase
    endfunction

    // Expected state visited at cycle idx of an instruction (-1 once it is over).
    function automatic int seq_at(input logic [5:0] op, input int idx);
        int s[5];
        s = '{0, 1, -1, -1, -1};
        case (op)
            6'h23:   s = '{0, 1, 2, 3, 4};
            6'h2B:   s = '{0, 1, 2, 5, -1};
            6'h00:   s = '{0, 1, 6, 7, -1};
            6'h04:   s = '{0, 1, 8, -1, -1};
            6'h08:   s = '{0, 1, 9, 10, -1};
            6'h02:   s = '{0, 1, 11, -1, -1};
            default: s = '{0, 1, -1, -1, -1};
        endcase
        if (idx < 0 || idx > 4) return -1;
        return s[idx];
    endfunction

    function automatic outs_t model_out(input int st, input logic [5:0] op,
                                        input logic [5:0] fn, input logic z);
        outs_t e;
        e = '0;
        e.alu_control = 3'b010;
        case (st)
            0:  begin e.ir_write = 1; e.alu_src_b = 2'b01; e.pc_en = 1; end
            1:  begin e.alu_src_b = 2'b11; e.illegal = !legal_op(op); end
            2:  begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
            3:  e.iord = 1;
            4:  begin e.mem_to_reg = 1; e.reg_write = 1; end
            5:  begin e.iord = 1; e.mem_write = 1; end
            6:  begin e.alu_src_a = 1; e.alu_control = funct_alu(fn); end
            7:  begin e.reg_dst = 1; e.reg_write = 1; end
            8:  begin e.alu_src_a = 1; e.pc_src = 2'b01; e.pc_en = z; e.alu_control = 3'b110; end
            9:  begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
            10: e.reg_write = 1;
            11: begin e.pc_src = 2'b10; e.pc_en = 1; end
            default: e = '0;
        endcase
        return e;
    endfunction

    function automatic outs_t dut_outs();
        outs_t a;
        a = {iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a,
             alu_src_b, pc_src, pc_en, alu_control, illegal_instr};
        return a;
    endfunction

    // Runs one instruction from its FETCH, checking every cycle, and reports
    // the observed FETCH-to-FETCH latency and the ALU control seen in EXECUTE.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                             input string tag, output int lat, output logic [2:0] exec_alu);
        int exp_st;
        bit done;
        opcode   = op;
        funct    = fn;
        zero     = z;
        lat      = 0;
        exec_alu = 3'b000;
        done     = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (!(i == 0 && primed)) @(negedge clk);
            if (i > 0 && state_dbg == 4'd0) begin
                done = 1'b1;
                break;
            end
            exp_st = seq_at(op, i);
            chk({tag, " state"}, 32'(state_dbg), 32'(exp_st));
            chk({tag, " outputs"}, 32'(dut_outs()), 32'(model_out(exp_st, op, fn, z)));
            if (state_dbg == 4'd6) exec_alu = alu_control;
            lat++;
        end
        primed = done;
        if (!done) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s timeout: no return to FETCH within 8 cycles", tag);
        end
    endtask

    vec_t vecs[14];

    initial begin
        int         lat;
        logic [2:0] ea;
        bit         found;
        logic [5:0] rop, rfn;
        logic       rz;
        logic [5:0] legal_list[6];

        vecs[0]  = '{6'h08, 6'h00, 1'b0, 4, 1'b0, 3'b000};  // addi 0x20030080
        vecs[1]  = '{6'h23, 6'h00, 1'b0, 5, 1'b0, 3'b000};  // lw 0x8C050000
        vecs[2]  = '{6'h2B, 6'h00, 1'b0, 4, 1'b0, 3'b000};  // sw 0xAC040000
        vecs[3]  = '{6'h04, 6'h10, 1'b1, 3, 1'b0, 3'b000};  // beq taken
        vecs[4]  = '{6'h04, 6'h10, 1'b0, 3, 1'b0, 3'b000};  // beq not taken
        vecs[5]  = '{6'h00, 6'h20, 1'b0, 4, 1'b1, 3'b010};
        vecs[6]  = '{6'h00, 6'h22, 1'b0, 4, 1'b1, 3'b110};
        vecs[7]  = '{6'h00, 6'h24, 1'b0, 4, 1'b1, 3'b000};
        vecs[8]  = '{6'h00, 6'h25, 1'b0, 4, 1'b1, 3'b001};
        vecs[9]  = '{6'h00, 6'h2A, 1'b1, 4, 1'b1, 3'b111};
        vecs[10] = '{6'h00, 6'h27, 1'b0, 4, 1'b1, 3'b010};  // unknown funct
        vecs[11] = '{6'h3F, 6'h00, 1'b0, 2, 1'b0, 3'b000};  // illegal opcode
        vecs[12] = '{6'h02, 6'h00, 1'b1, 3, 1'b0, 3'b000};  // j
        vecs[13] = '{6'h11, 6'h20, 1'b0, 2, 1'b0, 3'b000};  // another illegal

        legal_list = '{6'h00, 6'h02, 6'h04, 6'h08, 6'h23, 6'h2B};

        // Power-on reset held for three clocks
        rst_n  = 1'b0;
        opcode = 6'h00;
        funct  = 6'h00;
        zero   = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("reset state", 32'(state_dbg), 32'd0);
            chk("reset write enables", {28'd0, ir_write, pc_en, reg_write, mem_write}, 32'd0);
            chk("reset fetch selects", {26'd0, iord, alu_src_a, alu_src_b, pc_src}, 32'h04);
        end
        @(posedge clk);
        #2 rst_n = 1'b1;
        primed = 1'b0;
        @(negedge clk);
        chk("post-reset ir_write/pc_en", {30'd0, ir_write, pc_en}, 32'h3);
        primed = 1'b1;

        // Table-driven instruction vectors
        for (int v = 0; v < 14; v++) begin
            run_instr(vecs[v].op, vecs[v].fn, vecs[v].z, $sformatf("vec%0d", v), lat, ea);
            chk($sformatf("vec%0d latency", v), 32'(lat), 32'(vecs[v].exp_lat));
            if (vecs[v].chk_alu) chk($sformatf("vec%0d exec alu", v), 32'(ea), 32'(vecs[v].exp_alu));
        end

        // Reset asserted during MEMWRITE of a sw
        opcode = 6'h2B;
        funct  = 6'h00;
        zero   = 1'b0;
        found  = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (!(i == 0 && primed)) @(negedge clk);
            if (state_dbg == 4'd5) begin
                found = 1'b1;
                break;
            end
        end
        chk("reached MEMWRITE", 32'(found), 32'd1);
        chk("mem_write before abort", 32'(mem_write), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort mem_write", 32'(mem_write), 32'd0);
        chk("abort state", 32'(state_dbg), 32'd0);
        chk("abort write enables", {28'd0, ir_write, pc_en, reg_write, mem_write}, 32'd0);
        @(posedge clk);
        #1;
        chk("held reset state", 32'(state_dbg), 32'd0);
        chk("held reset writes", {28'd0, ir_write, pc_en, reg_write, mem_write}, 32'd0);
        @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        primed = 1'b0;
        run_instr(6'h23, 6'h00, 1'b0, "lw after abort", lat, ea);
        chk("lw after abort latency", 32'(lat), 32'd5);

        // Randomized instruction stream
        for (int r = 0; r < 40; r++) begin
            case ($urandom_range(0, 7))
                0, 1, 2, 3, 4, 5: rop = legal_list[$urandom_range(0, 5)];
                default:          rop = 6'($urandom);
            endcase
            rfn = ($urandom_range(0, 1) == 0) ? 6'($urandom) :
                  ((($urandom_range(0, 4)) == 0) ? 6'h20 : 6'h2A);
            rz  = 1'($urandom);
            run_instr(rop, rfn, rz, $sformatf("rand%0d op=%h", r, rop), lat, ea);
            chk($sformatf("rand%0d latency", r), 32'(lat),
                32'((rop == 6'h23) ? 5 :
                    (rop == 6'h2B || rop == 6'h00 || rop == 6'h08) ? 4 :
                    (rop == 6'h04 || rop == 6'h02) ? 3 : 2));
            if (rop == 6'h00) chk($sformatf("rand%0d exec alu", r), 32'(ea), 32'(funct_alu(rfn)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Main control unit for the multicycle MIPS core under cpu_top.
- Sequences the shared instruction/data memory, IR, register file, ALU and PC one micro-step per clock.
- Registered Moore FSM decodes opcode and drives datapath selects and write enables; an ALU decoder maps funct to the ALU operation.
- Supported: lw, sw, R-type (add, sub, and, or, slt), beq, addi, j.

Parameters:
- OP_W, 6, opcode and funct field width.
- ALUCTRL_W, 3, alu_control width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  OP_W  IR[31:26].
- funct  in  OP_W  IR[5:0].
- zero  in  1  ALU zero flag, valid combinationally in BRANCH.
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_write  out  1  memory write enable.
- ir_write  out  1  IR load enable.
- reg_dst  out  1  write register: 0 = rt, 1 = rd.
- mem_to_reg  out  1  write data: 0 = ALUOut, 1 = MDR.
- reg_write  out  1  register file write enable.
- alu_src_a  out  1  ALU A input: 0 = PC, 1 = A.
- alu_src_b  out  2  ALU B input: 00 = B, 01 = const 4, 10 = SignImm, 11 = SignImm<<2.
- pc_src  out  2  next PC: 00 = ALUResult, 01 = ALUOut, 10 = jump target.
- pc_en  out  1  PC load enable = pc_write | (branch & zero).
- alu_control  out  ALUCTRL_W  ALU operation: 010 add, 110 sub, 000 and, 001 or, 111 slt.
- illegal_instr  out  1  one-cycle pulse in DECODE for an unknown opcode.
- state_dbg  out  4  current state encoding, for the testbench.

Behaviour:
- State register resets asynchronously to FETCH. Outputs are a pure function of state plus opcode, funct and zero; no output registers.
- While rst_n=0, ir_write, pc_en, reg_write and mem_write are forced to 0; all other outputs take FETCH values.
- Reset mid-instruction aborts it. No partial write may occur after rst_n falls. Execution resumes at FETCH on the first clk edge after rst_n rises.
- Default for every output not listed in a state: 0 (alu_src_b 00, pc_src 00).
- States and per-state outputs:
  - FETCH: iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00, ir_write=1, pc_write=1. Next: DECODE.
  - DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target precomputed into ALUOut). Next by opcode:
    - lw 0x23, sw 0x2B -> MEMADR.
    - R-type 0x00 -> EXECUTE.
    - beq 0x04 -> BRANCH.
    - addi 0x08 -> ADDIEXEC.
    - j 0x02 -> JUMP.
    - Anything else -> FETCH with illegal_instr=1.
  - MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Next: MEMREAD if lw, MEMWRITE if sw.
  - MEMREAD: iord=1. Next: MEMWB.
  - MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1. Next: FETCH.
  - MEMWRITE: iord=1, mem_write=1. Next: FETCH.
  - EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=10. Next: ALUWB.
  - ALUWB: reg_dst=1, mem_to_reg=0, reg_write=1. Next: FETCH.
  - BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, branch=1. Next: FETCH.
  - ADDIEXEC: alu_src_a=1, alu_src_b=10, alu_op=00. Next: ADDIWB.
  - ADDIWB: reg_dst=0, mem_to_reg=0, reg_write=1. Next: FETCH.
  - JUMP: pc_src=10, pc_write=1. Next: FETCH.
- Latency in clocks, FETCH to next FETCH inclusive: lw 5; sw, R-type, addi 4; beq, j 3; illegal 2.
- ALU decode:
  - alu_op 00 -> 010.
  - alu_op 01 -> 110.
  - alu_op 10 by funct: 0x20 -> 010, 0x22 -> 110, 0x24 -> 000, 0x25 -> 001, 0x2A -> 111. Unknown funct -> 010, no flag.
  - alu_op 11 is unreachable and decodes to 010.
- beq with zero=0: pc_en=0 in BRANCH, PC holds PC+4 from FETCH.
- Unused state encodings recover to FETCH on the next edge.

Decomposition:
- Package mips_ctrl_pkg holds:
  - State enum, 4 bits: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEXEC=9, ADDIWB=10, JUMP=11.
  - Opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J.
  - Funct constants.
  - alu_op and alu_control encodings.
- Sub-module mips_alu_decoder (combinational: alu_op, funct -> alu_control), instantiated once.

Test Plan:
- Reset: hold rst_n=0 for 3 clocks, then release -> state_dbg=0 during reset, all write enables 0, ir_write=1 and pc_en=1 on the first cycle after release.
- addi 0x20030080 (opcode 0x08) -> states 0,1,9,10,0; reg_write=1 only in ADDIWB with reg_dst=0; alu_control=010 throughout.
- lw 0x8C050000 then sw 0xAC040000 -> lw: 0,1,2,3,4 with iord=1 in MEMREAD and mem_to_reg=1 in MEMWB; sw: 0,1,2,5 with mem_write=1 only in MEMWRITE.
- beq 0x10830010 -> with zero=1, pc_en=1 and pc_src=01 in BRANCH; repeated with zero=0, pc_en=0; both take 3 clocks.
- R-type funct sweep 0x20, 0x22, 0x24, 0x25, 0x2A -> alu_control in EXECUTE is 010, 110, 000, 001, 111; ALUWB has reg_dst=1. Unknown funct 0x27 -> 010.
- Illegal opcode 0x3F -> illegal_instr pulses in DECODE, then FETCH. Separately, assert rst_n=0 in MEMWRITE -> mem_write drops immediately and state_dbg=0.
